// File: rtl/pdp8l_tty_fifo_if.sv
// pdp8l_tty_fifo_if
//   Bus bundle for the buffered PDP-8/L teletype interface.
//   ARM register bus : armwrite, armwaddr, armwdata, armraddr -> armrdata
//   IOP bus          : iopstart, iopstop, ioopcode, cputodev
//                      -> devtocpu, AC_CLEAR, IO_SKIP, INT_RQST
//   master = ARM/CPU side (drives strobes), slave = the teletype block.
interface pdp8l_tty_fifo_if;
    logic        armwrite;
    logic [2:0]  armraddr;
    logic [2:0]  armwaddr;
    logic [31:0] armwdata;
    logic [31:0] armrdata;
    logic        iopstart;
    logic        iopstop;
    logic [11:0] ioopcode;
    logic [11:0] cputodev;
    logic [11:0] devtocpu;
    logic        AC_CLEAR;
    logic        IO_SKIP;
    logic        INT_RQST;

    modport master (
        output armwrite, armraddr, armwaddr, armwdata,
        output iopstart, iopstop, ioopcode, cputodev,
        input  armrdata, devtocpu, AC_CLEAR, IO_SKIP, INT_RQST
    );

    modport slave (
        input  armwrite, armraddr, armwaddr, armwdata,
        input  iopstart, iopstop, ioopcode, cputodev,
        output armrdata, devtocpu, AC_CLEAR, IO_SKIP, INT_RQST
    );
endinterface

// File: rtl/pdp8l_tty_fifo.sv
// pdp8l_tty_fifo
//   Buffered PDP-8/L teletype: keyboard FIFO (ARM pushes, CPU pops) and
//   printer FIFO (CPU pushes, ARM pops), each 2**DEPTHLOG2 x 12 bits.
//   CLOCK, RESET (sync, active-high) : clock / full reset
//   CSTEP                            : IOP inputs sampled only when high
//   BINIT                            : bus init, flushes both FIFOs
//   bus (slave)                      : ARM register bus + IOP bus
module pdp8l_tty_fifo #(
    parameter logic [5:0] KBDEV     = 6'o03,
    parameter int         DEPTHLOG2 = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic CSTEP,
    input  logic BINIT,
    pdp8l_tty_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTHLOG2;
    localparam int CW    = DEPTHLOG2 + 1;
    localparam logic [CW-1:0]        FULLCNT = CW'(DEPTH);
    localparam logic [DEPTHLOG2-1:0] PTR1    = DEPTHLOG2'(1);
    localparam logic [11:0] KBIO = 12'o6000 + {3'b000, KBDEV, 3'b000};
    localparam logic [11:0] TTIO = KBIO + 12'o0010;

    logic [11:0]          kbmem_q [DEPTH];
    logic [11:0]          prmem_q [DEPTH];
    logic [DEPTHLOG2-1:0] kbwp_q, kbwp_d, kbrp_q, kbrp_d;
    logic [DEPTHLOG2-1:0] prwp_q, prwp_d, prrp_q, prrp_d;
    logic [CW-1:0]        kbcnt_q, kbcnt_d, prcnt_q, prcnt_d;
    logic [15:0]          kbovr_q, kbovr_d, provr_q, provr_d;
    logic                 enable_q, enable_d, intenab_q, intenab_d;
    logic                 prflag_q, prflag_d;
    logic [11:0]          devtocpu_q, devtocpu_d;
    logic                 ac_clear_q, ac_clear_d, io_skip_q, io_skip_d;

    logic        kbflag, kbfull, prne, prfull, int_rqst;
    logic [11:0] kbhead, prhead;
    logic        arm_wr1, arm_wr2, arm_wr4, iop_go;
    logic        op_ksf, op_kcc, op_krs, op_kie, op_krb;
    logic        op_tsf, op_tcf, op_tpc, op_tsk, op_tls;
    logic        kb_flush, kb_push_req, kb_push, kb_pop, kb_ovr;
    logic        pr_flush, pr_pop_req, pr_push_req, pr_push, pr_pop, pr_ovr;

    assign kbflag   = (kbcnt_q != '0);
    assign kbfull   = (kbcnt_q == FULLCNT);
    assign prne     = (prcnt_q != '0);
    assign prfull   = (prcnt_q == FULLCNT);
    assign kbhead   = kbflag ? kbmem_q[kbrp_q] : 12'o0000;
    assign prhead   = prne   ? prmem_q[prrp_q] : 12'o0000;
    assign int_rqst = intenab_q & (kbflag | prflag_q);

    assign arm_wr1 = bus.armwrite && (bus.armwaddr == 3'd1);
    assign arm_wr2 = bus.armwrite && (bus.armwaddr == 3'd2);
    assign arm_wr4 = bus.armwrite && (bus.armwaddr == 3'd4);

    assign iop_go = CSTEP & bus.iopstart & enable_q;
    assign op_ksf = iop_go && (bus.ioopcode == KBIO + 12'd1);
    assign op_kcc = iop_go && (bus.ioopcode == KBIO + 12'd2);
    assign op_krs = iop_go && (bus.ioopcode == KBIO + 12'd4);
    assign op_kie = iop_go && (bus.ioopcode == KBIO + 12'd5);
    assign op_krb = iop_go && (bus.ioopcode == KBIO + 12'd6);
    assign op_tsf = iop_go && (bus.ioopcode == TTIO + 12'd1);
    assign op_tcf = iop_go && (bus.ioopcode == TTIO + 12'd2);
    assign op_tpc = iop_go && (bus.ioopcode == TTIO + 12'd4);
    assign op_tsk = iop_go && (bus.ioopcode == TTIO + 12'd5);
    assign op_tls = iop_go && (bus.ioopcode == TTIO + 12'd6);

    // Flush beats any same-cycle push or pop, and a discarded push is
    // not an overrun. A pop in the same cycle frees the slot a full push needs.
    assign kb_flush    = BINIT | (arm_wr1 & bus.armwdata[29]);
    assign kb_push_req = arm_wr1 & ~bus.armwdata[29];
    assign kb_pop      = (op_kcc | op_krb) & kbflag & ~kb_flush;
    assign kb_push     = kb_push_req & ~kb_flush & (~kbfull | kb_pop);
    assign kb_ovr      = kb_push_req & ~kb_flush & kbfull & ~kb_pop;

    assign pr_flush    = BINIT | (arm_wr2 & bus.armwdata[29]);
    assign pr_pop_req  = arm_wr2 & bus.armwdata[31];
    assign pr_push_req = op_tpc | op_tls;
    assign pr_pop      = pr_pop_req & prne & ~pr_flush;
    assign pr_push     = pr_push_req & ~pr_flush & (~prfull | pr_pop);
    assign pr_ovr      = pr_push_req & ~pr_flush & prfull & ~pr_pop;

    always_comb begin
        kbwp_d  = kbwp_q;
        kbrp_d  = kbrp_q;
        kbcnt_d = kbcnt_q;
        if (kb_flush) begin
            kbwp_d  = '0;
            kbrp_d  = '0;
            kbcnt_d = '0;
        end else begin
            if (kb_push) kbwp_d = kbwp_q + PTR1;
            if (kb_pop)  kbrp_d = kbrp_q + PTR1;
            if (kb_push && !kb_pop) kbcnt_d = kbcnt_q + CW'(1);
            if (!kb_push && kb_pop) kbcnt_d = kbcnt_q - CW'(1);
        end

        prwp_d  = prwp_q;
        prrp_d  = prrp_q;
        prcnt_d = prcnt_q;
        if (pr_flush) begin
            prwp_d  = '0;
            prrp_d  = '0;
            prcnt_d = '0;
        end else begin
            if (pr_push) prwp_d = prwp_q + PTR1;
            if (pr_pop)  prrp_d = prrp_q + PTR1;
            if (pr_push && !pr_pop) prcnt_d = prcnt_q + CW'(1);
            if (!pr_push && pr_pop) prcnt_d = prcnt_q - CW'(1);
        end

        kbovr_d = kbovr_q;
        provr_d = provr_q;
        if (arm_wr4) begin
            kbovr_d = '0;
            provr_d = '0;
        end else begin
            if (kb_ovr && kbovr_q != 16'hFFFF) kbovr_d = kbovr_q + 16'd1;
            if (pr_ovr && provr_q != 16'hFFFF) provr_d = provr_q + 16'd1;
        end

        enable_d  = arm_wr1 ? bus.armwdata[30] : enable_q;
        intenab_d = BINIT ? 1'b1 : (op_kie ? bus.cputodev[0] : intenab_q);

        // Later assignments win: ARM pop's set overrides TCF/TLS, BINIT overrides all.
        prflag_d = prflag_q;
        if (op_tcf)     prflag_d = 1'b0;
        if (op_tls)     prflag_d = (prcnt_d != FULLCNT);
        if (pr_pop_req) prflag_d = 1'b1;
        if (BINIT)      prflag_d = 1'b0;

        devtocpu_d = devtocpu_q;
        ac_clear_d = ac_clear_q;
        io_skip_d  = io_skip_q;
        if (iop_go) begin
            if (op_ksf)          io_skip_d  = kbflag;
            if (op_kcc | op_krb) ac_clear_d = 1'b1;
            if (op_krs | op_krb) devtocpu_d = kbhead;
            if (op_tsf)          io_skip_d  = prflag_q;
            if (op_tsk)          io_skip_d  = int_rqst;
        end else if (CSTEP && bus.iopstop && !bus.iopstart) begin
            devtocpu_d = '0;
            ac_clear_d = 1'b0;
            io_skip_d  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            kbwp_q     <= '0;
            kbrp_q     <= '0;
            kbcnt_q    <= '0;
            prwp_q     <= '0;
            prrp_q     <= '0;
            prcnt_q    <= '0;
            kbovr_q    <= '0;
            provr_q    <= '0;
            enable_q   <= 1'b1;
            intenab_q  <= 1'b1;
            prflag_q   <= 1'b0;
            devtocpu_q <= '0;
            ac_clear_q <= 1'b0;
            io_skip_q  <= 1'b0;
        end else begin
            kbwp_q     <= kbwp_d;
            kbrp_q     <= kbrp_d;
            kbcnt_q    <= kbcnt_d;
            prwp_q     <= prwp_d;
            prrp_q     <= prrp_d;
            prcnt_q    <= prcnt_d;
            kbovr_q    <= kbovr_d;
            provr_q    <= provr_d;
            enable_q   <= enable_d;
            intenab_q  <= intenab_d;
            prflag_q   <= prflag_d;
            devtocpu_q <= devtocpu_d;
            ac_clear_q <= ac_clear_d;
            io_skip_q  <= io_skip_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge CLOCK) begin
        if (!RESET && kb_push) kbmem_q[kbwp_q] <= bus.armwdata[11:0];
        if (!RESET && pr_push) prmem_q[prwp_q] <= bus.cputodev;
    end

    always_comb begin
        bus.armrdata = '0;
        case (bus.armraddr)
            3'd0: bus.armrdata = {16'h5446, 4'h1, 4'(DEPTHLOG2), 8'h0A};
            3'd1: bus.armrdata = {kbflag, enable_q, kbfull, 13'b0, 4'(kbcnt_q), kbhead};
            3'd2: bus.armrdata = {prflag_q, prne, prfull, 13'b0, 4'(prcnt_q), prhead};
            3'd3: bus.armrdata = {23'b0, intenab_q, 2'b0, KBDEV};
            3'd4: bus.armrdata = {kbovr_q, provr_q};
            default: bus.armrdata = '0;
        endcase
    end

    assign bus.devtocpu = devtocpu_q;
    assign bus.AC_CLEAR = ac_clear_q;
    assign bus.IO_SKIP  = io_skip_q;
    assign bus.INT_RQST = int_rqst;
endmodule

// File: tb/tb_pdp8l_tty_fifo.sv
// tb_pdp8l_tty_fifo
//   Directed bench for pdp8l_tty_fifo (KBDEV=03, DEPTHLOG2=2, DEPTH=4).
//   Stimulus queues hand-computed expectations; a negedge monitor pops
//   and compares them against the DUT outputs.
module tb_pdp8l_tty_fifo;
    localparam logic [11:0] KSF = 12'o6031, KCC = 12'o6032, KRS = 12'o6034;
    localparam logic [11:0] KIE = 12'o6035, KRB = 12'o6036;
    localparam logic [11:0] TSF = 12'o6041, TCF = 12'o6042, TPC = 12'o6044;
    localparam logic [11:0] TSK = 12'o6045, TLS = 12'o6046;
    localparam int S_RD = 0, S_DEV = 1, S_ACC = 2, S_SKP = 3, S_INT = 4;

    logic CLOCK, RESET, CSTEP, BINIT;
    pdp8l_tty_fifo_if bus();

    pdp8l_tty_fifo #(.KBDEV(6'o03), .DEPTHLOG2(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .CSTEP(CSTEP), .BINIT(BINIT), .bus(bus)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    always @(negedge CLOCK) begin
        chk_t        c;
        logic [31:0] act;
        while (q.size() != 0) begin
            c = q.pop_front();
            case (c.sel)
                S_RD:    act = bus.armrdata;
                S_DEV:   act = {20'b0, bus.devtocpu};
                S_ACC:   act = {31'b0, bus.AC_CLEAR};
                S_SKP:   act = {31'b0, bus.IO_SKIP};
                default: act = {31'b0, bus.INT_RQST};
            endcase
            checks++;
            if (act !== c.exp) begin
                failures++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic expect_v(input string name, input int sel, input logic [31:0] exp,
                            input logic [2:0] addr);
        chk_t c;
        bus.armraddr = addr;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        q.push_back(c);
        tick();
    endtask

    task automatic reg_chk(input string name, input logic [2:0] addr, input logic [31:0] exp);
        expect_v(name, S_RD, exp, addr);
    endtask

    task automatic out_chk(input string name, input int sel, input logic [31:0] exp);
        expect_v(name, sel, exp, 3'd0);
    endtask

    task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
        bus.armwrite = 1'b1;
        bus.armwaddr = a;
        bus.armwdata = d;
        tick();
        bus.armwrite = 1'b0;
    endtask

    task automatic iop(input logic [11:0] op, input logic [11:0] ac);
        bus.iopstart = 1'b1;
        bus.ioopcode = op;
        bus.cputodev = ac;
        tick();
        bus.iopstart = 1'b0;
    endtask

    task automatic iop_arm(input logic [11:0] op, input logic [11:0] ac,
                           input logic [2:0] a, input logic [31:0] d);
        bus.iopstart = 1'b1;
        bus.ioopcode = op;
        bus.cputodev = ac;
        bus.armwrite = 1'b1;
        bus.armwaddr = a;
        bus.armwdata = d;
        tick();
        bus.iopstart = 1'b0;
        bus.armwrite = 1'b0;
    endtask

    task automatic stop();
        bus.iopstop = 1'b1;
        tick();
        bus.iopstop = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        CSTEP = 1'b1;
        BINIT = 1'b0;
        bus.armwrite = 1'b0;
        bus.armraddr = 3'd0;
        bus.armwaddr = 3'd0;
        bus.armwdata = '0;
        bus.iopstart = 1'b0;
        bus.iopstop  = 1'b0;
        bus.ioopcode = '0;
        bus.cputodev = '0;
        repeat (3) @(posedge CLOCK);
        #1;
        RESET = 1'b0;

        reg_chk("rst_id", 3'd0, 32'h5446120A);
        reg_chk("rst_kb", 3'd1, 32'h40000000);
        reg_chk("rst_cfg", 3'd3, 32'h00000103);
        reg_chk("rst_ovr", 3'd4, 32'h00000000);
        out_chk("rst_int", S_INT, 32'd0);
        out_chk("rst_dev", S_DEV, 32'd0);

        arm_wr(3'd1, 32'h400000C1);
        arm_wr(3'd1, 32'h400000C2);
        reg_chk("kb_two", 3'd1, 32'hC00020C1);
        out_chk("kb_int", S_INT, 32'd1);
        iop(KSF, 12'o0);
        out_chk("ksf_1", S_SKP, 32'd1);
        iop(KRB, 12'o0);
        out_chk("krb_a", S_DEV, 32'o0301);
        out_chk("krb_acc", S_ACC, 32'd1);
        stop();
        out_chk("stop_dev", S_DEV, 32'd0);
        out_chk("stop_acc", S_ACC, 32'd0);
        out_chk("stop_skp", S_SKP, 32'd0);
        iop(KRB, 12'o0);
        out_chk("krb_b", S_DEV, 32'o0302);
        iop(KSF, 12'o0);
        out_chk("ksf_0", S_SKP, 32'd0);
        out_chk("int_0", S_INT, 32'd0);

        for (int i = 1; i <= 5; i++) arm_wr(3'd1, 32'h40000000 | 32'(i));
        reg_chk("kb_full", 3'd1, 32'hE0004001);
        reg_chk("kb_ovr1", 3'd4, 32'h00010000);
        iop_arm(KRB, 12'o0, 3'd1, 32'h40000006);
        out_chk("full_krb", S_DEV, 32'd1);
        reg_chk("full_pp", 3'd1, 32'hE0004002);
        reg_chk("full_novr", 3'd4, 32'h00010000);
        arm_wr(3'd1, 32'h60000000);
        reg_chk("kb_flush", 3'd1, 32'h40000000);
        iop_arm(KRB, 12'o0, 3'd1, 32'h40000077);
        out_chk("empty_krb", S_DEV, 32'd0);
        reg_chk("empty_push", 3'd1, 32'hC0001077);
        iop(KRS, 12'o0);
        out_chk("krs", S_DEV, 32'h077);
        reg_chk("krs_nopop", 3'd1, 32'hC0001077);
        iop(KRB, 12'o0);
        stop();
        reg_chk("kb_empty", 3'd1, 32'h40000000);

        iop(TLS, 12'h011);
        reg_chk("tls1", 3'd2, 32'hC0001011);
        iop(TLS, 12'h022);
        reg_chk("tls2", 3'd2, 32'hC0002011);
        iop(TLS, 12'h033);
        reg_chk("tls3", 3'd2, 32'hC0003011);
        iop(TLS, 12'h044);
        reg_chk("tls4", 3'd2, 32'h60004011);
        iop(TLS, 12'h055);
        reg_chk("tls5_drop", 3'd2, 32'h60004011);
        reg_chk("provr1", 3'd4, 32'h00010001);
        arm_wr(3'd2, 32'h80000000);
        reg_chk("arm_pop", 3'd2, 32'hC0003022);
        out_chk("int_pr", S_INT, 32'd1);
        iop_arm(TCF, 12'o0, 3'd2, 32'h80000000);
        reg_chk("set_wins", 3'd2, 32'hC0002033);
        iop(TCF, 12'o0);
        reg_chk("tcf", 3'd2, 32'h40002033);
        iop(TPC, 12'h066);
        iop(TPC, 12'h077);
        iop_arm(TPC, 12'h088, 3'd2, 32'h80000000);
        reg_chk("pr_full_pp", 3'd2, 32'hE0004044);
        reg_chk("pr_novr", 3'd4, 32'h00010001);

        iop(TCF, 12'o0);
        arm_wr(3'd1, 32'h40000012);
        iop(KIE, 12'o0);
        out_chk("kie0_int", S_INT, 32'd0);
        reg_chk("kie0_cfg", 3'd3, 32'h00000003);
        iop(TSK, 12'o0);
        out_chk("tsk0", S_SKP, 32'd0);
        iop(KIE, 12'o1);
        out_chk("kie1_int", S_INT, 32'd1);
        iop(TSK, 12'o0);
        out_chk("tsk1", S_SKP, 32'd1);
        iop(TSF, 12'o0);
        out_chk("tsf0", S_SKP, 32'd0);

        iop(KIE, 12'o0);
        arm_wr(3'd2, 32'h80000000);
        arm_wr(3'd1, 32'h00000034);
        BINIT = 1'b1;
        arm_wr(3'd1, 32'h00000099);
        BINIT = 1'b0;
        reg_chk("binit_kb", 3'd1, 32'h00000000);
        reg_chk("binit_pr", 3'd2, 32'h00000000);
        reg_chk("binit_cfg", 3'd3, 32'h00000103);
        reg_chk("binit_ovr", 3'd4, 32'h00010001);
        out_chk("binit_int", S_INT, 32'd0);

        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        reg_chk("rst2_ovr", 3'd4, 32'h00000000);
        reg_chk("rst2_kb", 3'd1, 32'h40000000);

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
